// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and byte-lane helpers for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  localparam int BYTE_W = 8;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Transfer size encodings on mem_size; the unused code 2'b11 behaves as a word.
  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  // Arbiter FSM state encodings.
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_XFER = 2'd1;
  localparam logic [1:0] ARB_DONE = 2'd2;

  // Number of bytes moved for a given size code.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: size_to_len = 3'd1;
      MEM_SIZE_H: size_to_len = 3'd2;
      MEM_SIZE_W: size_to_len = 3'd4;
      default:    size_to_len = 3'd4;
    endcase
  endfunction

  // Little-endian byte lane extraction.
  function automatic logic [BYTE_W-1:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
    byte_lane = word[BYTE_W*idx +: BYTE_W];
  endfunction

  // Replace one little-endian byte lane of a word.
  function automatic logic [31:0] insert_byte(input logic [31:0] word, input logic [1:0] idx,
                                              input logic [BYTE_W-1:0] b);
    insert_byte = word;
    insert_byte[BYTE_W*idx +: BYTE_W] = b;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter: shares one 8-bit RAM between instruction fetch
// and the MEM stage, moving one byte per cycle, little-endian, MEM has priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_data,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [BYTE_W-1:0]     ram_dout,
  output logic                  ram_wr,
  input  logic [BYTE_W-1:0]     ram_din,
  output logic                  stall_if_req,
  output logic                  stall_mem_req
);

  logic [1:0]            state_reg, state_next;
  logic [2:0]            k_reg, k_next;
  logic [2:0]            n_reg;
  logic                  owner_mem_reg;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [31:0]           wdata_reg;
  logic [31:0]           asm_reg;

  logic                  grant;
  logic                  grant_mem;
  logic [2:0]            grant_len;
  logic                  abort;
  logic                  issue;
  logic [2:0]            issue_idx;
  logic [ADDR_WIDTH-1:0] issue_base;
  logic [31:0]           issue_wdata;
  logic                  issue_we;
  logic                  done;

  // Next-state, grant and byte-issue decode. Byte 0 is issued in the grant cycle
  // straight from the request fields; later bytes come from the latched copies.
  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    grant       = 1'b0;
    grant_mem   = 1'b0;
    grant_len   = mem_req ? size_to_len(mem_size) : 3'd4;
    abort       = 1'b0;
    issue       = 1'b0;
    issue_idx   = 3'd0;
    issue_base  = base_reg;
    issue_wdata = wdata_reg;
    issue_we    = we_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (mem_req) begin
          grant       = 1'b1;
          grant_mem   = 1'b1;
          issue       = 1'b1;
          issue_base  = mem_addr;
          issue_wdata = mem_wdata;
          issue_we    = mem_we;
        end else if (if_req) begin
          grant       = 1'b1;
          issue       = 1'b1;
          issue_base  = if_addr;
          issue_wdata = ZERO_WORD;
          issue_we    = 1'b0;
        end
        if (grant) begin
          k_next = 3'd1;
          // A single-byte store has nothing left to issue or capture.
          state_next = (issue_we && grant_len == 3'd1) ? ARB_DONE : ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (!owner_mem_reg && !if_req) begin
          abort      = 1'b1;
          state_next = ARB_IDLE;
          k_next     = 3'd0;
        end else if (k_reg < n_reg) begin
          issue     = 1'b1;
          issue_idx = k_reg;
          k_next    = k_reg + 3'd1;
          // Stores finish as soon as the last byte is written.
          if (we_reg && (k_reg + 3'd1) == n_reg) state_next = ARB_DONE;
        end else begin
          state_next = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_next = ARB_IDLE;
        k_next     = 3'd0;
      end
      default: begin
        state_next = ARB_IDLE;
        k_next     = 3'd0;
      end
    endcase
  end

  // Transfer state: latch the request on grant, assemble read bytes as they return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ARB_IDLE;
      k_reg         <= 3'd0;
      n_reg         <= 3'd0;
      owner_mem_reg <= 1'b0;
      we_reg        <= 1'b0;
      base_reg      <= '0;
      wdata_reg     <= ZERO_WORD;
      asm_reg       <= ZERO_WORD;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      if (grant) begin
        owner_mem_reg <= grant_mem;
        we_reg        <= issue_we;
        base_reg      <= issue_base;
        wdata_reg     <= issue_wdata;
        n_reg         <= grant_len;
        // Cleared so that bytes beyond the transfer length read as zero.
        asm_reg       <= ZERO_WORD;
      end else if (state_reg == ARB_XFER && !we_reg && !abort) begin
        // ram_din holds the byte issued in the previous cycle, i.e. byte k-1.
        asm_reg <= insert_byte(asm_reg, 2'(k_reg - 3'd1), ram_din);
      end
    end
  end

  // Outputs are idle-zero and forced quiet while reset is asserted.
  assign done          = (state_reg == ARB_DONE) && !rst;
  assign ram_wr        = issue && issue_we && !rst;
  assign ram_a         = (issue && !rst) ? issue_base + ADDR_WIDTH'(issue_idx) : '0;
  assign ram_dout      = ram_wr ? byte_lane(issue_wdata, issue_idx[1:0]) : '0;
  assign if_done       = done && !owner_mem_reg;
  assign mem_done      = done && owner_mem_reg;
  assign if_data       = if_done ? asm_reg : ZERO_WORD;
  assign mem_rdata     = (mem_done && !we_reg) ? asm_reg : ZERO_WORD;
  assign stall_if_req  = if_req && !if_done;
  assign stall_mem_req = mem_req && !mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        stall_if_req;
  logic        stall_mem_req;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .stall_if_req(stall_if_req), .stall_mem_req(stall_mem_req)
  );

  always #5 clk = ~clk;

  // 1 KiB RAM model: read data appears the cycle after the address.
  logic [7:0] ram [0:1023];
  initial ram_din = 8'h00;
  always @(posedge clk) begin
    ram_din <= ram[ram_a[9:0]];
    if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
  end

  typedef struct {
    bit          is_if;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          n;
    int          done_cyc;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ram_a"}, ram_a, 0);
    chk({tag, " ram_wr"}, ram_wr, 0);
    chk({tag, " ram_dout"}, ram_dout, 0);
    chk({tag, " if_data"}, if_data, 0);
    chk({tag, " if_done"}, if_done, 0);
    chk({tag, " mem_rdata"}, mem_rdata, 0);
    chk({tag, " mem_done"}, mem_done, 0);
    chk({tag, " stall_if"}, stall_if_req, 0);
    chk({tag, " stall_mem"}, stall_mem_req, 0);
  endtask

  // Applies one table vector starting in the current cycle (T0) and checks every
  // cycle up to and including the done pulse.
  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] exp_a;
    logic [31:0] sh;
    if (v.is_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      mem_req = 1'b1; mem_we = v.we; mem_size = v.size;
      mem_addr = v.addr; mem_wdata = v.wdata;
    end
    for (int c = 0; c <= v.done_cyc; c++) begin
      @(negedge clk);
      if (c < v.n) begin
        exp_a = v.addr + 32'(c);
        sh    = v.wdata >> (8 * c);
        chk("ram_a", ram_a, exp_a);
        chk("ram_wr", ram_wr, v.we);
        chk("ram_dout", ram_dout, v.we ? sh[7:0] : 8'h00);
      end else begin
        chk("ram_a idle", ram_a, 0);
        chk("ram_wr idle", ram_wr, 0);
      end
      if (v.is_if) begin
        chk("if_done", if_done, c == v.done_cyc);
        chk("if_data", if_data, (c == v.done_cyc) ? v.exp_data : 32'h0);
        chk("mem_done quiet", mem_done, 0);
        chk("stall_if", stall_if_req, c != v.done_cyc);
      end else begin
        chk("mem_done", mem_done, c == v.done_cyc);
        chk("mem_rdata", mem_rdata, (c == v.done_cyc) ? v.exp_data : 32'h0);
        chk("if_done quiet", if_done, 0);
        chk("stall_mem", stall_mem_req, c != v.done_cyc);
      end
      step();
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    $display("txn %0d: %s we=%0d size=%0d addr=%h data=%h done@T%0d",
             idx, v.is_if ? "IF " : "MEM", v.we, v.size, v.addr,
             v.we ? v.wdata : v.exp_data, v.done_cyc);
  endtask

  initial begin
    vec_t tail;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h10; ram[10'h103] = 8'h00;
    ram[10'h031] = 8'h80; ram[10'h032] = 8'hFF;
    ram[10'h3FF] = 8'h11; ram[10'h000] = 8'h22;

    //           is_if we size   addr           wdata          n  done expected
    vecs[0] = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         4, 5, 32'h0010_0513};
    vecs[1] = '{1'b0, 1'b1, 2'b10, 32'h0000_0020, 32'hDEAD_BEEF, 4, 4, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 2'b01, 32'h0000_0031, 32'h0,         2, 3, 32'h0000_FF80};
    vecs[3] = '{1'b0, 1'b0, 2'b10, 32'h0000_0020, 32'h0,         4, 5, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b0, 2'b00, 32'h0000_0022, 32'h0,         1, 2, 32'h0000_00AD};
    vecs[5] = '{1'b0, 1'b1, 2'b01, 32'h0000_0050, 32'h1234_CAFE, 2, 2, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 2'b11, 32'h0000_0050, 32'h0,         4, 5, 32'h0000_CAFE};
    vecs[7] = '{1'b0, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,         2, 3, 32'h0000_2211};
    vecs[8] = '{1'b0, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_00AB, 1, 1, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0,         1, 2, 32'h0000_00AB};

    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    step();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Simultaneous requests: a byte store wins, the fetch follows after DONE.
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b00; mem_addr = 32'h40; mem_wdata = 32'h5A;
    @(negedge clk);
    chk("both ram_a", ram_a, 32'h40);
    chk("both ram_wr", ram_wr, 1);
    chk("both ram_dout", ram_dout, 8'h5A);
    chk("both stall_if", stall_if_req, 1);
    step();
    @(negedge clk);
    chk("both mem_done", mem_done, 1);
    chk("both stall_mem", stall_mem_req, 0);
    chk("both stall_if T1", stall_if_req, 1);
    chk("both ram_wr T1", ram_wr, 0);
    step();
    mem_req = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      if (c < 6) begin
        chk("both if ram_a", ram_a, 32'h100 + 32'(c - 2));
        chk("both if ram_wr", ram_wr, 0);
      end
      chk("both if_done", if_done, c == 7);
      chk("both stall_if", stall_if_req, c != 7);
      if (c == 7) chk("both if_data", if_data, 32'h0010_0513);
      step();
    end
    if_req = 1'b0;
    chk("ram 0x40", ram[10'h040], 8'h5A);
    $display("txn simul: MEM store 0x5A@0x40 then IF fetch 0x100");

    // Fetch abort with a load pending behind it.
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk); chk("abort ram_a T0", ram_a, 32'h100); step();
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h22;
    @(negedge clk); chk("abort ram_a T1", ram_a, 32'h101); chk("abort mem_done T1", mem_done, 0); step();
    if_req = 1'b0;
    @(negedge clk); chk("abort ram_a T2", ram_a, 32'h0); chk("abort if_done T2", if_done, 0); step();
    @(negedge clk); chk("abort grant T3", ram_a, 32'h22); chk("abort stall_mem T3", stall_mem_req, 1); step();
    @(negedge clk); chk("abort ram_a T4", ram_a, 32'h0); chk("abort if_done T4", if_done, 0); step();
    @(negedge clk);
    chk("abort mem_done T5", mem_done, 1);
    chk("abort mem_rdata T5", mem_rdata, 32'hAD);
    chk("abort if_done T5", if_done, 0);
    step();
    mem_req = 1'b0;
    $display("txn abort: IF 0x100 aborted, MEM load 0x22 granted at T3");

    // Reset in the middle of a word store.
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h60; mem_wdata = 32'h1122_3344;
    @(negedge clk); chk("rst ram_a T0", ram_a, 32'h60); chk("rst ram_dout T0", ram_dout, 8'h44); step();
    @(negedge clk); chk("rst ram_a T1", ram_a, 32'h61); chk("rst ram_dout T1", ram_dout, 8'h33); step();
    rst = 1'b1; mem_req = 1'b0;
    @(negedge clk); chk("rst ram_wr T2", ram_wr, 0); chk("rst mem_done T2", mem_done, 0); step();
    rst = 1'b0;
    @(negedge clk); chk_all_zero("rst T3"); step();
    @(negedge clk); chk_all_zero("rst T4"); step();
    $display("txn reset: word store 0x60 cut at T2");
    tail = '{1'b0, 1'b0, 2'b10, 32'h0000_0060, 32'h0, 4, 5, 32'h0000_3344};
    run_vec(tail, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
